// File: rtl/jzjpcc_memory_stage.sv
// jzjpcc_memory_stage: RV32I memory stage plus the M/W pipeline register.
// Optional misaligned-access trap enabled by defining JZJPCC_MISALIGN_CHECK_EN.
module jzjpcc_memory_stage #(
   parameter int DMEM_ADDR_W = 12
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [4:0]             rdAddr_memory,
   input  logic                   rdWriteEnable_memory,
   input  logic                   rdSource_memory,
   input  logic                   memRead_memory,
   input  logic                   memWrite_memory,
   input  logic [2:0]             funct3_memory,
   input  logic [31:0]            aluResult_memory,
   input  logic [31:0]            rs2_memory,
   output logic [DMEM_ADDR_W-1:0] dmem_addr,
   output logic [31:0]            dmem_wdata,
   output logic [3:0]             dmem_byteEn,
   output logic                   dmem_we,
   output logic                   dmem_re,
   input  logic [31:0]            dmem_rdata,
   output logic [4:0]             rdAddr_writeback,
   output logic                   rdWriteEnable_writeback,
   output logic                   rdSource_writeback,
   output logic [31:0]            memoryOut_writeback,
   output logic [31:0]            aluResult_writeback,
   output logic [2:0]             funct3_writeback,
   output logic [3:0]             memByteMask_writeback,
   output logic                   fwdValid,
   output logic [4:0]             fwdAddr,
   output logic [31:0]            fwdData,
   output logic [31:0]            loadCount,
   output logic [31:0]            storeCount
`ifdef JZJPCC_MISALIGN_CHECK_EN
   ,
   output logic                   misalignErr,
   output logic [31:0]            misalignAddr
`endif
);

   logic [3:0]  w_mask;
   logic [3:0]  w_maskEff;
   logic [31:0] w_wdata;
   logic        w_misalign;
   logic        w_enter;

   logic [4:0]  r_rdAddr;
   logic        r_rdWe;
   logic        r_rdSrc;
   logic [31:0] r_alu;
   logic [2:0]  r_funct3;
   logic [3:0]  r_mask;
   logic [31:0] r_loadCount;
   logic [31:0] r_storeCount;

   // Byte-lane mask and lane-replicated store data from the access width
   always_comb begin
      w_mask  = 4'b0000;
      w_wdata = rs2_memory;
      unique case (funct3_memory[1:0])
         2'b00: begin
            w_mask  = 4'b0001 << aluResult_memory[1:0];
            w_wdata = {4{rs2_memory[7:0]}};
         end
         2'b01: begin
            w_mask  = 4'b0011 << {aluResult_memory[1], 1'b0};
            w_wdata = {2{rs2_memory[15:0]}};
         end
         2'b10: begin
            w_mask  = 4'b1111;
            w_wdata = rs2_memory;
         end
         default: begin
            w_mask  = 4'b0000;
            w_wdata = rs2_memory;
         end
      endcase
   end

`ifdef JZJPCC_MISALIGN_CHECK_EN
   logic        r_misErr;
   logic [31:0] r_misAddr;

   // Flag halves on odd bytes and words off a 4-byte boundary
   always_comb begin
      w_misalign = 1'b0;
      if (memRead_memory | memWrite_memory) begin
         if (funct3_memory[1:0] == 2'b01)
            w_misalign = aluResult_memory[0];
         else if (funct3_memory[1:0] == 2'b10)
            w_misalign = |aluResult_memory[1:0];
      end
   end

   // Sticky error flag capturing only the first offending address
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_misErr  <= 1'b0;
         r_misAddr <= 32'h0;
      end else if (w_misalign & ~stall & ~flush & ~r_misErr) begin
         r_misErr  <= 1'b1;
         r_misAddr <= aluResult_memory;
      end
   end

   assign misalignErr  = r_misErr;
   assign misalignAddr = r_misAddr;
`else
   assign w_misalign = 1'b0;
`endif

   assign w_maskEff = w_misalign ? 4'b0000 : w_mask;
   assign w_enter   = ~stall & ~flush & ~w_misalign;

   // reset_n gates the strobe so a write cannot slip out during reset
   assign dmem_addr   = aluResult_memory[DMEM_ADDR_W+1:2];
   assign dmem_wdata  = w_wdata;
   assign dmem_byteEn = memWrite_memory ? w_maskEff : 4'b0000;
   assign dmem_we     = memWrite_memory & w_enter & reset_n;
   assign dmem_re     = ~stall;

   assign fwdValid = rdWriteEnable_memory & ~memRead_memory &
                     (rdAddr_memory != 5'd0);
   assign fwdAddr  = rdAddr_memory;
   assign fwdData  = aluResult_memory;

   // M/W register: stall holds, flush or misalign inserts a bubble
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rdAddr <= 5'd0;
         r_rdWe   <= 1'b0;
         r_rdSrc  <= 1'b0;
         r_alu    <= 32'h0;
         r_funct3 <= 3'd0;
         r_mask   <= 4'd0;
      end else if (!stall) begin
         if (flush | w_misalign) begin
            r_rdAddr <= 5'd0;
            r_rdWe   <= 1'b0;
            r_rdSrc  <= 1'b0;
            r_alu    <= 32'h0;
            r_funct3 <= 3'd0;
            r_mask   <= 4'd0;
         end else begin
            r_rdAddr <= rdAddr_memory;
            r_rdWe   <= rdWriteEnable_memory &
                        (rdAddr_memory != 5'd0);
            r_rdSrc  <= rdSource_memory;
            r_alu    <= aluResult_memory;
            r_funct3 <= funct3_memory;
            r_mask   <= w_mask;
         end
      end
   end

   // Retired access counters, wrapping naturally at 2^32
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_loadCount  <= 32'h0;
         r_storeCount <= 32'h0;
      end else if (w_enter) begin
         if (memRead_memory)
            r_loadCount <= r_loadCount + 32'd1;
         if (memWrite_memory)
            r_storeCount <= r_storeCount + 32'd1;
      end
   end

   assign rdAddr_writeback        = r_rdAddr;
   assign rdWriteEnable_writeback = r_rdWe;
   assign rdSource_writeback      = r_rdSrc;
   assign aluResult_writeback     = r_alu;
   assign funct3_writeback        = r_funct3;
   assign memByteMask_writeback   = r_mask;
   assign memoryOut_writeback     = dmem_rdata;
   assign loadCount               = r_loadCount;
   assign storeCount              = r_storeCount;

endmodule

// File: tb/tb_jzjpcc_memory_stage.sv
// tb_jzjpcc_memory_stage: directed and random checks of the memory stage
// against a byte-level reference model with its own RAM image.
module tb_jzjpcc_memory_stage;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall, flush;
   logic [4:0]  rdAddr_memory;
   logic        rdWriteEnable_memory, rdSource_memory;
   logic        memRead_memory, memWrite_memory;
   logic [2:0]  funct3_memory;
   logic [31:0] aluResult_memory, rs2_memory;
   logic [11:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_byteEn;
   logic        dmem_we, dmem_re;
   logic [31:0] dmem_rdata;
   logic [4:0]  rdAddr_writeback;
   logic        rdWriteEnable_writeback, rdSource_writeback;
   logic [31:0] memoryOut_writeback, aluResult_writeback;
   logic [2:0]  funct3_writeback;
   logic [3:0]  memByteMask_writeback;
   logic        fwdValid;
   logic [4:0]  fwdAddr;
   logic [31:0] fwdData, loadCount, storeCount;
`ifdef JZJPCC_MISALIGN_CHECK_EN
   logic        misalignErr;
   logic [31:0] misalignAddr;
`endif

   int tests = 0;
   int fails = 0;

   logic [31:0] ram    [4096];
   logic [31:0] refmem [4096];

   logic [4:0]  e_rd;
   logic        e_we, e_src, e_err;
   logic [31:0] e_alu, e_rdata, e_lc, e_sc, e_eaddr;
   logic [2:0]  e_f3;
   logic [3:0]  e_mask;

   jzjpcc_memory_stage #(.DMEM_ADDR_W(12)) dut (
      .clock(clock), .reset_n(reset_n),
      .stall(stall), .flush(flush),
      .rdAddr_memory(rdAddr_memory),
      .rdWriteEnable_memory(rdWriteEnable_memory),
      .rdSource_memory(rdSource_memory),
      .memRead_memory(memRead_memory),
      .memWrite_memory(memWrite_memory),
      .funct3_memory(funct3_memory),
      .aluResult_memory(aluResult_memory),
      .rs2_memory(rs2_memory),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_byteEn(dmem_byteEn), .dmem_we(dmem_we),
      .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
      .rdAddr_writeback(rdAddr_writeback),
      .rdWriteEnable_writeback(rdWriteEnable_writeback),
      .rdSource_writeback(rdSource_writeback),
      .memoryOut_writeback(memoryOut_writeback),
      .aluResult_writeback(aluResult_writeback),
      .funct3_writeback(funct3_writeback),
      .memByteMask_writeback(memByteMask_writeback),
      .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData),
      .loadCount(loadCount), .storeCount(storeCount)
`ifdef JZJPCC_MISALIGN_CHECK_EN
      ,
      .misalignErr(misalignErr), .misalignAddr(misalignAddr)
`endif
   );

   always #5 clock = ~clock;

   // Synchronous RAM driven by whatever the DUT presents
   always @(posedge clock) begin
      if (dmem_re)
         dmem_rdata <= ram[dmem_addr];
      if (dmem_we)
         for (int i = 0; i < 4; i++)
            if (dmem_byteEn[i])
               ram[dmem_addr][8*i +: 8] <= dmem_wdata[8*i +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] m_mask(input logic [2:0] f3,
                                         input logic [31:0] a);
      int lane;
      case (f3[1:0])
         2'b00: begin lane = int'(a % 4); return 4'(1 << lane); end
         2'b01: begin lane = int'((a / 2) % 2) * 2;
                      return 4'(3 << lane); end
         2'b10: return 4'hF;
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                           input logic [31:0] d);
      case (f3[1:0])
         2'b00: return (d % 256) * 32'h01010101;
         2'b01: return (d % 65536) * 32'h00010001;
         default: return d;
      endcase
   endfunction

   function automatic logic m_mis(input logic [2:0] f3,
                                  input logic [31:0] a,
                                  input logic acc);
`ifdef JZJPCC_MISALIGN_CHECK_EN
      if (!acc) return 1'b0;
      if (f3[1:0] == 2'b01) return (a % 2) != 0;
      if (f3[1:0] == 2'b10) return (a % 4) != 0;
      return 1'b0;
`else
      return 1'b0 & acc & f3[0] & a[0];
`endif
   endfunction

   task automatic m_reset();
      e_rd = 0; e_we = 0; e_src = 0; e_alu = 0; e_f3 = 0;
      e_mask = 0; e_lc = 0; e_sc = 0; e_err = 0; e_eaddr = 0;
   endtask

   task automatic chk_reg(input string t);
      chk({t, ".rd"},    32'(rdAddr_writeback), 32'(e_rd));
      chk({t, ".we"},    32'(rdWriteEnable_writeback), 32'(e_we));
      chk({t, ".src"},   32'(rdSource_writeback), 32'(e_src));
      chk({t, ".alu"},   aluResult_writeback, e_alu);
      chk({t, ".f3"},    32'(funct3_writeback), 32'(e_f3));
      chk({t, ".mask"},  32'(memByteMask_writeback), 32'(e_mask));
      chk({t, ".mout"},  memoryOut_writeback, e_rdata);
      chk({t, ".lcnt"},  loadCount, e_lc);
      chk({t, ".scnt"},  storeCount, e_sc);
`ifdef JZJPCC_MISALIGN_CHECK_EN
      chk({t, ".merr"},  32'(misalignErr), 32'(e_err));
      chk({t, ".maddr"}, misalignAddr, e_eaddr);
`endif
   endtask

   // One cycle: drive, check combinational outputs, clock, check state
   task automatic step(input string t, input logic st, input logic fl,
                       input logic [4:0] rd, input logic we,
                       input logic src, input logic mr,
                       input logic mw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
      logic mis;
      logic [31:0] idx;
      stall = st; flush = fl; rdAddr_memory = rd;
      rdWriteEnable_memory = we; rdSource_memory = src;
      memRead_memory = mr; memWrite_memory = mw;
      funct3_memory = f3; aluResult_memory = a; rs2_memory = d;
      mis = m_mis(f3, a, mr | mw);
      idx = (a / 4) % 4096;
      #3;
      chk({t, ".addr"},  32'(dmem_addr), idx);
      chk({t, ".wdata"}, dmem_wdata, m_wdata(f3, d));
      chk({t, ".ben"},   32'(dmem_byteEn),
          (mw && !mis) ? 32'(m_mask(f3, a)) : 32'h0);
      chk({t, ".dwe"},   32'(dmem_we), 32'(mw && !st && !fl && !mis));
      chk({t, ".dre"},   32'(dmem_re), 32'(!st));
      chk({t, ".fwdv"},  32'(fwdValid), 32'(we && !mr && rd != 0));
      chk({t, ".fwda"},  32'(fwdAddr), 32'(rd));
      chk({t, ".fwdd"},  fwdData, a);
      @(posedge clock);
      if (!st) begin
         e_rdata = refmem[idx];
         if (mw && !fl && !mis)
            for (int i = 0; i < 4; i++)
               if (m_mask(f3, a)[i])
                  refmem[idx][8*i +: 8] = m_wdata(f3, d)[8*i +: 8];
         if (fl || mis) begin
            e_rd = 0; e_we = 0; e_src = 0; e_alu = 0;
            e_f3 = 0; e_mask = 0;
         end else begin
            e_rd = rd; e_we = we && rd != 0; e_src = src;
            e_alu = a; e_f3 = f3; e_mask = m_mask(f3, a);
            if (mr) e_lc = e_lc + 1;
            if (mw) e_sc = e_sc + 1;
         end
         if (mis && !fl && !e_err) begin
            e_err = 1; e_eaddr = a;
         end
      end
      #1;
      chk_reg(t);
   endtask

   initial begin
      logic [31:0] v;
      for (int i = 0; i < 4096; i++) begin
         v = $urandom;
         ram[i] = v;
         refmem[i] = v;
      end
      ram[12'h080] = 32'h12345678;
      refmem[12'h080] = 32'h12345678;
      dmem_rdata = 32'h0;
      e_rdata = 32'h0;
      m_reset();

      reset_n = 1'b0; stall = 1'b1; flush = 1'b0;
      rdAddr_memory = 0; rdWriteEnable_memory = 0;
      rdSource_memory = 0; memRead_memory = 0;
      memWrite_memory = 1'b1; funct3_memory = 3'b010;
      aluResult_memory = 0; rs2_memory = 0;
      #2;
      chk("rst.dwe", 32'(dmem_we), 32'h0);
      @(posedge clock); @(posedge clock);
      #1;
      chk_reg("rst");
      reset_n = 1'b1;

      step("sb", 0, 0, 5'd0, 0, 0, 0, 1, 3'b000,
           32'h103, 32'h000000AB);
      chk("sb.ram", ram[12'h040] & 32'hFF000000, 32'hAB000000);
      step("lh", 0, 0, 5'd5, 1, 1, 1, 0, 3'b001,
           32'h202, 32'h0);
      step("lhwb", 0, 0, 5'd0, 0, 0, 0, 0, 3'b011, 32'h0, 32'h0);
      step("alu", 0, 0, 5'd3, 1, 0, 0, 0, 3'b000,
           32'h11111111, 32'h0);
      for (int i = 0; i < 3; i++)
         step("stl", 1, 0, 5'd7, 1, 0, 0, 1, 3'b010,
              32'hDEADBEEF, 32'h5);
      step("rel", 0, 0, 5'd7, 1, 0, 0, 0, 3'b000,
           32'hDEADBEEF, 32'h0);
      step("fls", 0, 1, 5'd9, 1, 0, 0, 1, 3'b010,
           32'h400, 32'hCAFEF00D);
      step("stf", 1, 1, 5'd9, 1, 0, 1, 0, 3'b010,
           32'h400, 32'h0);
      step("x0", 0, 0, 5'd0, 1, 0, 0, 0, 3'b000,
           32'h55, 32'h0);
      step("nop3", 0, 0, 5'd4, 1, 1, 1, 0, 3'b011,
           32'h13, 32'h0);
      step("sw6", 0, 0, 5'd0, 0, 0, 0, 1, 3'b010,
           32'h6, 32'h77);
      step("sh5", 0, 0, 5'd0, 0, 0, 0, 1, 3'b001,
           32'h5, 32'hBEEF);

      for (int n = 0; n < 400; n++) begin
         logic mr, mw;
         logic [1:0] kind;
         kind = 2'($urandom_range(0, 3));
         mr = (kind == 2'd1);
         mw = (kind == 2'd2);
         step("rnd", ($urandom_range(0, 9) < 2),
              ($urandom_range(0, 9) < 1),
              5'($urandom_range(0, 31)), 1'($urandom),
              mr, mr, mw, 3'($urandom),
              $urandom, $urandom);
      end

      step("pre", 0, 0, 5'd2, 1, 0, 0, 1, 3'b010, 32'h8, 32'h99);
      stall = 1'b0; memWrite_memory = 1'b1; flush = 1'b0;
      funct3_memory = 3'b010; aluResult_memory = 32'h10;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mrst.dwe", 32'(dmem_we), 32'h0);
      m_reset();
      chk_reg("mrst");
      stall = 1'b1;
      @(posedge clock);
      #1;
      chk_reg("mrst2");
      reset_n = 1'b1;
      step("post", 0, 0, 5'd6, 1, 0, 0, 1, 3'b000,
           32'h21, 32'h3C);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jzjpcc_memory_stage.md
Name: jzjpcc_memory_stage

Overview:
- Memory stage of the pipelined RV32I core, between execute and writeback.
- Presents address, store data and byte-lane enables to the synchronous data RAM (1-cycle read latency).
- Owns the memory/writeback pipeline register that drives the writeback-stage interface fields.
- Provides forwarding data to the hazard unit and retired load/store counters.

Parameters:
- DMEM_ADDR_W, 12, word-address width of data RAM (byte address bits [DMEM_ADDR_W+1:2] used).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hold M/W register and suppress new memory access
- flush  in  1  replace the instruction entering M/W with a bubble
- rdAddr_memory  in  5  destination register from execute
- rdWriteEnable_memory  in  1  register write request
- rdSource_memory  in  1  0 = ALU result, 1 = memory data
- memRead_memory  in  1  instruction is a load
- memWrite_memory  in  1  instruction is a store
- funct3_memory  in  3  load/store width code
- aluResult_memory  in  32  ALU result / effective byte address
- rs2_memory  in  32  store data (unaligned, low bits valid)
- dmem_addr  out  DMEM_ADDR_W  word address to RAM
- dmem_wdata  out  32  lane-shifted store data
- dmem_byteEn  out  4  RAM byte write enables
- dmem_we  out  1  RAM write strobe
- dmem_re  out  1  RAM read enable (RAM output holds when 0)
- dmem_rdata  in  32  RAM read data, valid 1 cycle after dmem_re
- rdAddr_writeback, rdWriteEnable_writeback, rdSource_writeback  out  5/1/1  registered writeback fields
- memoryOut_writeback  out  32  equal to dmem_rdata (unregistered pass-through)
- aluResult_writeback  out  32  registered ALU result
- funct3_writeback  out  3  registered funct3
- memByteMask_writeback  out  4  registered byte mask for load muxing
- fwdValid, fwdAddr, fwdData  out  1/5/32  M-stage forwarding (ALU result, non-loads only)
- loadCount, storeCount  out  32  retired access counters

Behaviour:
- Reset (async, reset_n=0): every registered writeback output 0, counters 0, error state cleared; dmem_we=0 immediately.
- Byte mask from funct3[1:0] and aluResult[1:0]: 00 (byte) -> 4'b0001<<a[1:0]; 01 (half) -> 4'b0011<<{a[1],1'b0}; 10 (word) -> 4'b1111; 11 -> 4'b0000.
- dmem_wdata: byte replicated ×4, half replicated ×2, word as-is; dmem_byteEn = mask when store, else 0.
- dmem_we = memWrite_memory & ~stall & ~flush; dmem_re = ~stall; dmem_addr = aluResult[DMEM_ADDR_W+1:2], combinational.
- M/W register, rising edge:
  - stall=1: hold all fields; stall has priority over flush.
  - flush=1 (no stall): load bubble; rdWriteEnable=0, rdAddr=0, rdSource=0, other fields 0.
  - else: capture rdAddr, rdWriteEnable (forced 0 when rdAddr==0), rdSource, aluResult, funct3, mask.
- memoryOut_writeback = dmem_rdata; correct for the instruction in writeback because RAM data is 1 cycle latent and dmem_re=0 holds it during stall.
- Forwarding: fwdValid = rdWriteEnable_memory & ~memRead_memory & rdAddr_memory!=0; fwdAddr/fwdData from the memory-stage inputs.
- Counters: increment on a clock where an access enters M/W (no stall, no flush), loadCount on memRead, storeCount on memWrite; wrap 0xFFFFFFFF -> 0.
- Reset asserted mid-store: dmem_we drops asynchronously; no partial write issued after reset.

Optional Feature:
- Macro JZJPCC_MISALIGN_CHECK_EN.
- Defined: half access with a[0]=1, or word access with a[1:0]!=0, is misaligned. dmem_we and the byte mask are forced 0. The M/W entry is converted to a bubble. Sticky output misalignErr (1 bit, added port) is set until reset; misalignAddr (32, added port) latches the first offending address.
- Undefined: no check and no extra ports; the access proceeds with the mask rules above (word ignores a[1:0], half ignores a[0]).

Test Plan:
- SB a=0x103, rs2=0x000000AB -> dmem_byteEn=4'b1000, dmem_wdata=0xABABABAB, dmem_we=1, dmem_addr=0x040, storeCount 0->1.
- LH a=0x202, rdAddr=5; RAM word 0x12345678 -> next cycle memByteMask_writeback=4'b1100, funct3_writeback=3'b001, memoryOut_writeback=0x12345678, rdSource_writeback=1.
- ALU op rd=7 result 0xDEADBEEF with stall=1 for 3 cycles -> writeback fields unchanged during stall, dmem_we=0; fields update on the cycle after stall releases.
- flush=1 with a store at input -> dmem_we=0, next cycle rdWriteEnable_writeback=0, counters unchanged.
- rdAddr=0, rdWriteEnable=1 -> rdWriteEnable_writeback=0, fwdValid=0.
- With JZJPCC_MISALIGN_CHECK_EN: SW a=0x0006 -> dmem_we=0, misalignErr=1, misalignAddr=0x00000006. Then assert reset_n=0 mid-cycle -> misalignErr=0 immediately.
